// File: rtl/pushdly_pkg.sv
// Shared widths, latency offset and FSM state encoding for the pushdly delay-change controller.
package pushdly_pkg;

    localparam int PD_LAT_OFS = 3;
    localparam int PD_DLY_W   = 5;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/pushdly_ctrl_if.sv
// Config-register side of pushdly_ctrl: req/ack delay-change handshake, BUSY and FSM state for debug.
interface pushdly_ctrl_if;
    import pushdly_pkg::*;

    // Handshake: requester raises DLY_REQ with DLY_VAL and holds REQ until the one-cycle
    // DLY_ACK pulse; DLY_VAL is latched on acceptance and REQ seen during the ack cycle is ignored.
    logic                DLY_REQ;
    logic [PD_DLY_W-1:0] DLY_VAL;
    logic                DLY_ACK;
    logic                BUSY;
    state_e              DBG_STATE;

    modport master (output DLY_REQ, output DLY_VAL, input DLY_ACK, input BUSY, input DBG_STATE);
    modport slave  (input DLY_REQ, input DLY_VAL, output DLY_ACK, output BUSY, output DBG_STATE);

endinterface

// File: rtl/pushdly_ctrl.sv
// Run-time delay-change sequencer for one pushdly channel: drain old pulses, load DELAY, mask stale SRL output.
// Optional dropped-pulse counter on DROP_CNT is built when PUSHDLY_DROP_CNT_EN is defined.
module pushdly_ctrl
    import pushdly_pkg::*;
#(
    parameter logic [PD_DLY_W-1:0] DEF_DLY   = 5'd0,
    parameter logic [CNT_W-1:0]    FLUSH_LEN = 6'd35
) (
    input  logic                CLK,
    input  logic                RST_N,
    pushdly_ctrl_if.slave       cfg,
    input  logic                DIN,
    output logic                PD_DIN,
    output logic [PD_DLY_W-1:0] PD_DELAY,
    input  logic                PD_DOUT,
    output logic                DOUT
`ifdef PUSHDLY_DROP_CNT_EN
    ,
    output logic [7:0]          DROP_CNT
`endif
);

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PD_DLY_W-1:0] pend, pend_nxt;
    logic [PD_DLY_W-1:0] dly_q, dly_nxt;
    logic                ack_q, ack_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= DEF_DLY;
            dly_q <= DEF_DLY;
            ack_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            dly_q <= dly_nxt;
            ack_q <= ack_nxt;
        end
    end

    // In DRAIN, cnt holds the number of drain cycles still to run (old DELAY+3 in total).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        dly_nxt   = dly_q;
        ack_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg.DLY_REQ && !ack_q) begin
                    if (cfg.DLY_VAL == dly_q) begin
                        ack_nxt = 1'b1;
                    end else begin
                        pend_nxt  = cfg.DLY_VAL;
                        cnt_nxt   = CNT_W'(dly_q) + CNT_W'(PD_LAT_OFS);
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                dly_nxt   = pend;
                cnt_nxt   = FLUSH_LEN - 1'b1;
                state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    ack_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign PD_DIN        = DIN & (state == ST_IDLE);
    assign DOUT          = PD_DOUT & (state != ST_FLUSH);
    assign PD_DELAY      = dly_q;
    assign cfg.DLY_ACK   = ack_q;
    assign cfg.BUSY      = (state != ST_IDLE);
    assign cfg.DBG_STATE = state;

`ifdef PUSHDLY_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= '0;
        end else if (DIN && (state != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign DROP_CNT = drop_q;
`endif

endmodule
